// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared constants for the 7-segment display blocks: the
//               dark (all segments off) code, segment bit positions and the
//               active-low hex-to-segment table, plus a decode helper.
// Revision    : 1.0  initial release
// ============================================================================
package seg7_pkg;

    // Width of a segment code (a..g).
    localparam int SEG_W = 7;

    // Active-low code with every segment off.
    localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

    // Bit position of each segment within a code.
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-low segment codes; element k is the glyph for hex digit k.
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    // Nibble plus blank flag to active-low code; blank wins over the nibble.
    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nibble,
                                                    input logic       blank);
        if (blank) begin
            return SEG_OFF;
        end
        return SEG_TABLE[nibble];
    endfunction

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_scan_hex7seg.sv
`default_nettype none
// ============================================================================
// Module      : hex7seg
// Description : Purely combinational hex digit decoder for an active-low
//               7-segment display (bit 0 = segment a ... bit 6 = segment g).
//               A set blank flag turns every segment off.
// Ports       : i_nibble  hex value 0..F
//               i_blank   1 = show nothing
//               o_code    active-low segment code
// Revision    : 1.0  initial release
// ============================================================================
module hex7seg
    import seg7_pkg::*;
(
    input  logic [3:0]       i_nibble,
    input  logic             i_blank,
    output logic [SEG_W-1:0] o_code
);

    always_comb begin
        o_code = hex_to_seg(i_nibble, i_blank);
    end

endmodule : hex7seg
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan
// Description : Time-multiplexed multi-digit 7-segment scan controller.
//               Stores a nibble and a blank flag per digit, steps through the
//               digits every PRESCALE clocks, and for each digit slot emits
//               one blanking cycle (all anodes off) carrying the decoded code
//               and a load strobe, followed by PRESCALE-1 cycles with that
//               digit's anode driven low.
// Ports       : Clock    system clock, rising edge
//               Reset    asynchronous active-high reset
//               Enable   scan run; low = display dark, scan restarts at digit 0
//               WrEn     digit write strobe
//               WrAddr   digit index to write (out-of-range ignored)
//               WrData   hex nibble to store
//               WrBlank  1 = stored digit shows nothing
//               Seg      active-low segment code for the downstream register
//               SegE     one-cycle load strobe for the downstream register
//               AnodeN   active-low one-hot digit select
// Revision    : 1.0  initial release
// ============================================================================
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 16,
    parameter int n        = 7
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       Enable,
    input  logic                       WrEn,
    input  logic [$clog2(DIGITS)-1:0]  WrAddr,
    input  logic [3:0]                 WrData,
    input  logic                       WrBlank,
    output logic [n-1:0]               Seg,
    output logic                       SegE,
    output logic [DIGITS-1:0]          AnodeN
);

    localparam int                c_IW      = $clog2(DIGITS);
    localparam int                c_CW      = $clog2(PRESCALE);
    localparam logic [c_CW-1:0]   c_CNT_MAX = c_CW'(PRESCALE - 1);
    localparam logic [c_IW-1:0]   c_IDX_MAX = c_IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] c_ONE_HOT = {{(DIGITS-1){1'b0}}, 1'b1};

    // Scan position.
    logic [c_CW-1:0]         r_cnt;
    logic [c_IW-1:0]         r_idx;

    // Digit store.
    logic [DIGITS-1:0][3:0]  r_nib;
    logic [DIGITS-1:0]       r_blank;

    // Output registers.
    logic [n-1:0]            r_seg;
    logic                    r_sege;
    logic [DIGITS-1:0]       r_anode_n;

    logic                    w_addr_ok;
    logic [SEG_W-1:0]        w_code;
    logic [DIGITS-1:0]       w_anode_on;
    logic                    w_slot_start;

    // Non-power-of-two digit counts leave unused address codes.
    assign w_addr_ok    = (32'(WrAddr) < 32'(DIGITS));
    assign w_slot_start = (r_cnt == '0);
    assign w_anode_on   = ~(c_ONE_HOT << r_idx);

    // ------------------------------------------------------------------------
    // Digit store. The output register samples the store on the same edge a
    // write lands, so a write to the digit being loaded only shows on its
    // next slot.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        always_ff @(posedge Clock or posedge Reset) begin
            if (Reset) begin
                r_nib[gi]   <= 4'h0;
                r_blank[gi] <= 1'b1;
            end else if (WrEn && w_addr_ok && (WrAddr == c_IW'(gi))) begin
                r_nib[gi]   <= WrData;
                r_blank[gi] <= WrBlank;
            end
        end
    end

    hex7seg u_dec (
        .i_nibble (r_nib[r_idx]),
        .i_blank  (r_blank[r_idx]),
        .o_code   (w_code)
    );

    // ------------------------------------------------------------------------
    // Slot sequencing.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (!Enable) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_cnt == c_CNT_MAX) begin
            r_cnt <= '0;
            r_idx <= (r_idx == c_IDX_MAX) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Output registers. The first cycle of every slot keeps all anodes off
    // while the downstream register loads the new code; this gap is what
    // keeps the previous digit's segments from ghosting onto the next one,
    // and it guarantees SegE never coincides with a lit anode.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_seg     <= SEG_OFF;
            r_sege    <= 1'b0;
            r_anode_n <= '1;
        end else if (!Enable) begin
            r_seg     <= SEG_OFF;
            r_sege    <= 1'b0;
            r_anode_n <= '1;
        end else if (w_slot_start) begin
            r_seg     <= w_code;
            r_sege    <= 1'b1;
            r_anode_n <= '1;
        end else begin
            r_sege    <= 1'b0;
            r_anode_n <= w_anode_on;
        end
    end

    assign Seg    = r_seg;
    assign SegE   = r_sege;
    assign AnodeN = r_anode_n;

endmodule : seg7_scan
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan
// Description : Self-checking bench for seg7_scan (DIGITS=4, PRESCALE=16).
//               A behavioural model tracks the scan position as a count of
//               enabled clock edges and predicts the outputs from it.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_scan;

    localparam int c_DIGITS   = 4;
    localparam int c_PRESCALE = 16;

    logic       clk;
    logic       rst;
    logic       en;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_blank;
    logic [6:0] seg;
    logic       sege;
    logic [3:0] anoden;

    int n_vec;
    int n_err;

    // Reference model state.
    int         m_p;
    logic [3:0] m_nib   [c_DIGITS];
    logic       m_blank [c_DIGITS];
    logic [6:0] e_seg;
    logic       e_sege;
    logic [3:0] e_an;

    seg7_scan #(
        .DIGITS   (c_DIGITS),
        .PRESCALE (c_PRESCALE),
        .n        (7)
    ) u_dut (
        .Clock   (clk),
        .Reset   (rst),
        .Enable  (en),
        .WrEn    (wr_en),
        .WrAddr  (wr_addr),
        .WrData  (wr_data),
        .WrBlank (wr_blank),
        .Seg     (seg),
        .SegE    (sege),
        .AnodeN  (anoden)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] dec(input logic [3:0] v, input logic b);
        if (b) return 7'h7F;
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic model_reset();
        m_p    = 0;
        e_seg  = 7'h7F;
        e_sege = 1'b0;
        e_an   = 4'hF;
        for (int i = 0; i < c_DIGITS; i++) begin
            m_nib[i]   = 4'h0;
            m_blank[i] = 1'b1;
        end
    endtask

    // One clock edge of the reference: outputs from the pre-edge store, then
    // the write takes effect.
    task automatic model_edge();
        int ph;
        int sl;
        if (!en) begin
            m_p    = 0;
            e_seg  = 7'h7F;
            e_sege = 1'b0;
            e_an   = 4'hF;
        end else begin
            ph = m_p % c_PRESCALE;
            sl = (m_p / c_PRESCALE) % c_DIGITS;
            e_an = 4'hF;
            if (ph == 0) begin
                e_seg  = dec(m_nib[sl], m_blank[sl]);
                e_sege = 1'b1;
            end else begin
                e_an[sl] = 1'b0;
                e_sege   = 1'b0;
            end
            m_p++;
        end
        if (wr_en && (int'(wr_addr) < c_DIGITS)) begin
            m_nib[wr_addr]   = wr_data;
            m_blank[wr_addr] = wr_blank;
        end
    endtask

    task automatic step(input logic e, input logic we, input logic [1:0] a,
                        input logic [3:0] d, input logic b);
        en       = e;
        wr_en    = we;
        wr_addr  = a;
        wr_data  = d;
        wr_blank = b;
        @(posedge clk);
        model_edge();
        #1;
        chk("seg", 32'(seg), 32'(e_seg));
        chk("sege", 32'(sege), 32'(e_sege));
        chk("anoden", 32'(anoden), 32'(e_an));
        chk("overlap", 32'(sege && (anoden != 4'hF)), 32'd0);
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
    endtask

    logic [6:0] r_seq [4];
    int         n_pulse;
    int         n_lo0;
    int         guard;
    logic [6:0] old_code;

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        en       = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = 2'd0;
        wr_data  = 4'h0;
        wr_blank = 1'b0;
        model_reset();

        // Reset state.
        #3;
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_sege", 32'(sege), 32'd0);
        chk("rst_anoden", 32'(anoden), 32'hF);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        // Idle with the scan disabled.
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 2'd0, 4'h0, 1'b0);

        // Load 1,2,3,F.
        step(1'b0, 1'b1, 2'd0, 4'h1, 1'b0);
        step(1'b0, 1'b1, 2'd1, 4'h2, 1'b0);
        step(1'b0, 1'b1, 2'd2, 4'h3, 1'b0);
        step(1'b0, 1'b1, 2'd3, 4'hF, 1'b0);

        // One full scan from the start.
        n_pulse = 0;
        n_lo0   = 0;
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
            if (sege) begin
                if (n_pulse < 4) r_seq[n_pulse] = seg;
                n_pulse++;
            end
            if (anoden == 4'b1110) n_lo0++;
        end
        chk("pulses_per_scan", 32'(n_pulse), 32'd4);
        chk("seq0", 32'(r_seq[0]), 32'h79);
        chk("seq1", 32'(r_seq[1]), 32'h24);
        chk("seq2", 32'(r_seq[2]), 32'h30);
        chk("seq3", 32'(r_seq[3]), 32'h0E);
        chk("digit0_on_cycles", 32'(n_lo0), 32'd15);

        // Blank digit 2 mid-scan.
        run(5);
        step(1'b1, 1'b1, 2'd2, 4'h3, 1'b1);
        run(70);

        // Write digit 2 on the very edge that loads it.
        guard = 0;
        while (!((m_p % 16 == 0) && ((m_p / 16) % 4 == 2)) && guard < 200) begin
            run(1);
            guard++;
        end
        chk("rbw_reach", 32'(guard < 200), 32'd1);
        old_code = dec(m_nib[2], m_blank[2]);
        step(1'b1, 1'b1, 2'd2, 4'h5, 1'b0);
        chk("rbw_old_code", 32'(seg), 32'(old_code));
        guard = 0;
        while (!((m_p % 16 == 0) && ((m_p / 16) % 4 == 2)) && guard < 200) begin
            run(1);
            guard++;
        end
        step(1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
        chk("rbw_new_code", 32'(seg), 32'h12);
        run(20);

        // Enable drop for 3 cycles mid-scan.
        step(1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
        step(1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
        step(1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
        chk("reen_sege", 32'(sege), 32'd1);
        chk("reen_anoden", 32'(anoden), 32'hF);
        chk("reen_seg", 32'(seg), 32'(dec(m_nib[0], m_blank[0])));
        run(30);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0),
                 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset at cnt=7, idx=1.
        step(1'b0, 1'b1, 2'd1, 4'h8, 1'b0);
        guard = 0;
        while (m_p != 23 && guard < 100) begin
            run(1);
            guard++;
        end
        chk("arst_reach", 32'(m_p), 32'd23);
        #2 rst = 1'b1;
        #1;
        chk("arst_seg", 32'(seg), 32'h7F);
        chk("arst_sege", 32'(sege), 32'd0);
        chk("arst_anoden", 32'(anoden), 32'hF);
        model_reset();
        #2 rst = 1'b0;
        run(64);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_seg7_scan
`default_nettype wire
